// File: rtl/memory_unit.sv
// ============================================================================
// memory_unit : read-only 1024x32 page-table fixture ROM with valid/ready
//               request and response channels (IDLE -> READ -> RESPOND).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module memory_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid_i,
    output logic        mem_req_ready_o,
    input  logic [31:0] mem_addr_i,
    output logic        mem_resp_valid_o,
    input  logic        mem_resp_ready_i,
    output logic [31:0] mem_data_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_ACCESS = 2'd1,
        RESPOND     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;

    logic [9:0]  w_index;
    logic        w_in_range;
    logic [31:0] w_rom_word;
    logic        w_addr_unused;

    // Byte offset within a word carries no information for a word-wide ROM.
    assign w_addr_unused = ^addr_q[1:0];
    assign w_index       = addr_q[11:2];
    assign w_in_range    = (addr_q[31:12] == 20'd0);

    always_comb begin
        w_rom_word = 32'h0000_0000;
        if (w_in_range) begin
            case (w_index)
                10'd256: w_rom_word = 32'h0000_0801;
                10'd257: w_rom_word = 32'h1234_0000;
                10'd512: w_rom_word = 32'h1000_000F;
                10'd513: w_rom_word = 32'h1100_000F;
                10'd514: w_rom_word = 32'h1200_0007;
                default: w_rom_word = 32'h0000_0000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (mem_req_valid_i) begin
                    addr_d  = mem_addr_i;
                    state_d = READ_ACCESS;
                end
            end
            READ_ACCESS: begin
                data_d  = w_rom_word;
                state_d = RESPOND;
            end
            RESPOND: begin
                if (mem_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Handshake flags decode the state register only, keeping inputs off output paths.
    assign mem_req_ready_o  = (state_q == IDLE);
    assign mem_resp_valid_o = (state_q == RESPOND);
    assign mem_data_o       = data_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_unit.sv
// ============================================================================
// tb_memory_unit : directed self-checking bench for memory_unit.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_memory_unit;

    logic        clk;
    logic        rst;
    logic        mem_req_valid_i;
    logic        mem_req_ready_o;
    logic [31:0] mem_addr_i;
    logic        mem_resp_valid_o;
    logic        mem_resp_ready_i;
    logic [31:0] mem_data_o;

    int total;
    int bad;

    memory_unit u_dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req_valid_i  (mem_req_valid_i),
        .mem_req_ready_o  (mem_req_ready_o),
        .mem_addr_i       (mem_addr_i),
        .mem_resp_valid_o (mem_resp_valid_o),
        .mem_resp_ready_i (mem_resp_ready_i),
        .mem_data_o       (mem_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the machine in IDLE; returns at the falling
    // edge after the handshake edge so the next request can go out immediately.
    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input string tag);
        check({tag, "_req_ready"}, {31'd0, mem_req_ready_o}, 32'd1);
        mem_req_valid_i  = 1'b1;
        mem_addr_i       = a;
        mem_resp_ready_i = 1'b1;
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        mem_addr_i      = 32'hDEAD_BEEF;
        check({tag, "_busy_ready"}, {31'd0, mem_req_ready_o}, 32'd0);
        check({tag, "_early_valid"}, {31'd0, mem_resp_valid_o}, 32'd0);
        @(negedge clk);
        check({tag, "_resp_valid"}, {31'd0, mem_resp_valid_o}, 32'd1);
        check({tag, "_data"}, mem_data_o, e);
        @(negedge clk);
        check({tag, "_idle_valid"}, {31'd0, mem_resp_valid_o}, 32'd0);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b0;
        mem_req_valid_i  = 1'b0;
        mem_addr_i       = 32'h0;
        mem_resp_ready_i = 1'b0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, mem_req_ready_o}, 32'd1);
        check("rst_valid", {31'd0, mem_resp_valid_o}, 32'd0);
        check("rst_data", mem_data_o, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, mem_req_ready_o}, 32'd1);
        check("post_rst_valid", {31'd0, mem_resp_valid_o}, 32'd0);
        check("post_rst_data", mem_data_o, 32'h0);

        // Unwritten words and page-table fixture
        do_read(32'h0000_0000, 32'h0000_0000, "rd000");
        do_read(32'h0000_0004, 32'h0000_0000, "rd004");
        do_read(32'h0000_0400, 32'h0000_0801, "rd400");
        do_read(32'h0000_0100, 32'h0000_0000, "rd100");
        do_read(32'h0000_0404, 32'h1234_0000, "rd404");
        do_read(32'h0000_0408, 32'h0000_0000, "rd408");
        do_read(32'h0000_0800, 32'h1000_000F, "rd800");
        do_read(32'h0000_0808, 32'h1200_0007, "rd808");
        do_read(32'h0000_080C, 32'h0000_0000, "rd80c");
        do_read(32'h0000_0403, 32'h0000_0801, "rd403_offset");

        // Range boundary and aliasing of out-of-range addresses
        do_read(32'h0000_0FFC, 32'h0000_0000, "rdffc");
        do_read(32'h0000_1000, 32'h0000_0000, "rd1000");
        do_read(32'h0001_0000, 32'h0000_0000, "rd10000");
        do_read(32'h0000_1400, 32'h0000_0000, "rd1400_alias");
        do_read(32'h8000_0804, 32'h0000_0000, "rd80000804_alias");

        // Backpressure on 0x804, with a competing request held meanwhile
        mem_req_valid_i  = 1'b1;
        mem_addr_i       = 32'h0000_0804;
        mem_resp_ready_i = 1'b0;
        @(negedge clk);
        mem_addr_i = 32'h0000_0400;
        @(negedge clk);
        check("bp_valid0", {31'd0, mem_resp_valid_o}, 32'd1);
        check("bp_data0", mem_data_o, 32'h1100_000F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", i), {31'd0, mem_resp_valid_o}, 32'd1);
            check($sformatf("bp_hold_data%0d", i), mem_data_o, 32'h1100_000F);
            check($sformatf("bp_hold_ready%0d", i), {31'd0, mem_req_ready_o}, 32'd0);
        end
        mem_req_valid_i  = 1'b0;
        mem_resp_ready_i = 1'b1;
        @(negedge clk);
        check("bp_done_valid", {31'd0, mem_resp_valid_o}, 32'd0);
        check("bp_done_ready", {31'd0, mem_req_ready_o}, 32'd1);
        check("bp_data_stable", mem_data_o, 32'h1100_000F);
        @(negedge clk);
        check("bp_idle_again", {31'd0, mem_req_ready_o}, 32'd1);
        check("bp_no_second_resp", {31'd0, mem_resp_valid_o}, 32'd0);

        // Back-to-back stream with a reset landing in RESPOND
        do_read(32'h0000_0808, 32'h1200_0007, "s0");
        do_read(32'h0000_0400, 32'h0000_0801, "s1");
        do_read(32'h0000_1404, 32'h0000_0000, "s2");
        do_read(32'h0000_0804, 32'h1100_000F, "s3");
        do_read(32'h0000_080C, 32'h0000_0000, "s4");

        mem_req_valid_i  = 1'b1;
        mem_addr_i       = 32'h0000_0800;
        mem_resp_ready_i = 1'b0;
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        @(negedge clk);
        check("s5_resp_valid", {31'd0, mem_resp_valid_o}, 32'd1);
        check("s5_data", mem_data_o, 32'h1000_000F);
        rst = 1'b0;
        #1;
        check("s5_rst_valid", {31'd0, mem_resp_valid_o}, 32'd0);
        check("s5_rst_ready", {31'd0, mem_req_ready_o}, 32'd1);
        check("s5_rst_data", mem_data_o, 32'h0);
        @(negedge clk);
        rst              = 1'b1;
        mem_resp_ready_i = 1'b1;
        @(negedge clk);
        check("s5_after_valid", {31'd0, mem_resp_valid_o}, 32'd0);

        do_read(32'h0000_0404, 32'h1234_0000, "s6");
        do_read(32'h0000_0000, 32'h0000_0000, "s7");
        do_read(32'h0000_0800, 32'h1000_000F, "s8");
        do_read(32'h0000_0FFC, 32'h0000_0000, "s9");

        // Response-ready held high in IDLE must not fabricate a response
        repeat (3) @(negedge clk);
        check("idle_ready_hi_valid", {31'd0, mem_resp_valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_unit.md
# memory_unit

Read-only word memory that backs the page-table walker in the TLB subsystem. It accepts one read request at a time over a valid/ready request channel and returns one 32-bit word over a valid/ready response channel. Contents are a fixed 4 KiB image holding a two-level page-table fixture. Writes are not supported.

## Interface
Parameters:
- none. Depth is fixed at 1024 words × 32 bits (byte range 0x000–0xFFF).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `mem_req_valid_i`  in  1  request valid.
- `mem_req_ready_o`  out  1  request ready; high only in IDLE.
- `mem_addr_i`  in  32  byte address of the request.
- `mem_resp_valid_o`  out  1  response valid.
- `mem_resp_ready_i`  in  1  response ready from the consumer.
- `mem_data_o`  out  32  response data word.

## Operation
- Storage contents, by word index (index = byte address >> 2):
  - [256] (0x400) = 0x00000801
  - [257] (0x404) = 0x12340000
  - [512] (0x800) = 0x1000000F
  - [513] (0x804) = 0x1100000F
  - [514] (0x808) = 0x12000007
  - All other words = 0x00000000.
- The contents are constant. Reset does not alter them.
- Address decode:
  - addr[1:0] is ignored.
  - If addr[31:12] == 0, the word index is addr[11:2].
  - Any address ≥ 0x1000 is out of range and returns 0x00000000. No error is signalled.
- State machine with three states:
  - IDLE: `mem_req_ready_o` = 1. On `mem_req_valid_i` = 1 at a rising edge, latch `mem_addr_i` and go to READ_ACCESS.
  - READ_ACCESS: look up the latched address, register the word into `mem_data_o`, go to RESPOND. Takes 1 cycle.
  - RESPOND: `mem_resp_valid_o` = 1. Hold until `mem_resp_ready_i` = 1 at a rising edge (handshake), then go to IDLE.
- `mem_data_o` stays stable from entry into RESPOND until the next READ_ACCESS.
- The request channel is ignored outside IDLE. A held `mem_req_valid_i` is not re-accepted until the state machine is back in IDLE.
- Undefined encoding of the 2-bit state register: go to IDLE.

## Timing
- Reset values (rst = 0, takes effect immediately):
  - state = IDLE
  - `mem_req_ready_o` = 1
  - `mem_resp_valid_o` = 0
  - `mem_data_o` = 0
  - latched address = 0
- Reset asserted mid-transaction aborts it. No response is produced for the aborted request.
- Latency: request accepted at edge N → READ_ACCESS during cycle N → RESPOND (`mem_resp_valid_o` = 1, data valid) after edge N+1.
- With `mem_resp_ready_i` already high, the handshake completes at edge N+2. `mem_req_ready_o` is high again after N+2, so the minimum request-to-request spacing is 3 cycles.
- Response backpressure: `mem_resp_valid_o` and `mem_data_o` are held indefinitely while `mem_resp_ready_i` = 0.
- `mem_resp_ready_i` high in IDLE or READ_ACCESS has no effect.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst = 0 for 2 cycles, then release → `mem_req_ready_o` = 1, `mem_resp_valid_o` = 0, `mem_data_o` = 0.
- Unwritten words: read 0x000, 0x004, 0x100 → 0x00000000 each. Each response arrives one cycle after acceptance.
- Page-table fixture:
  - 0x400 → 0x00000801, 0x404 → 0x12340000, 0x408 → 0x00000000.
  - 0x800 → 0x1000000F, 0x804 → 0x1100000F, 0x808 → 0x12000007, 0x80C → 0x00000000.
- Range boundary: 0xFFC → 0x00000000 (last valid word); 0x1000 → 0x00000000; 0x10000 → 0x00000000. No hang in any case.
- Backpressure and hold: keep `mem_resp_ready_i` = 0 for 5 cycles after reading 0x804 → `mem_resp_valid_o` stays 1, data stays 0x1100000F, `mem_req_ready_o` stays 0. Then raise ready → exactly one handshake and a return to IDLE.
- Back-to-back stress: issue 10 sequential reads mixing the addresses above, including an async reset asserted while in RESPOND → all reads return their expected values. After the reset the machine is in IDLE with valid low, and the next read is correct.
